// File: rtl/glb_dma_hdr_queue_pkg.sv
// Shared types and field offsets for the GLB DMA header queue.
// Slot fields are held at 32 bits; the top masks writes to the live widths.
package glb_dma_hdr_queue_pkg;

  localparam int SLOT_FIELD_W = 32;
  localparam int DONE_CNT_W   = 8;

  typedef struct packed {
    logic                    valid;
    logic [SLOT_FIELD_W-1:0] start_addr;
    logic [SLOT_FIELD_W-1:0] num_words;
  } dma_hdr_slot_t;

  localparam logic [1:0] FIELD_VALIDATE = 2'd0;
  localparam logic [1:0] FIELD_START    = 2'd1;
  localparam logic [1:0] FIELD_NUM      = 2'd2;
  localparam logic [1:0] FIELD_STATUS   = 2'd3;

endpackage

// File: rtl/glb_dma_hdr_pio_dec.sv
// PIO decode: registered ack/nack/read data, combinational write strobe.
// Ports: PIO request in, slot state in, read/ack/nack out, write strobe out.
module glb_dma_hdr_pio_dec
  import glb_dma_hdr_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 6,
  localparam int IW = $clog2(QUEUE_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic                      rd,
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  input  dma_hdr_slot_t             slots [QUEUE_DEPTH],
  input  logic [IW-1:0]             head_idx,
  input  logic [DONE_CNT_W-1:0]     done_cnt,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic                      ack,
  output logic                      nack,
  output logic                      wr_en,
  output logic [IW-1:0]             wr_slot,
  output logic [1:0]                wr_field
);

  logic [REG_ADDR_WIDTH-3:0] slot_sel;
  logic [IW-1:0]             idx;
  logic [1:0]                field;
  logic                      in_range;
  logic                      locked;
  logic                      bad;
  logic                      req;
  dma_hdr_slot_t             sel;
  logic [DATA_WIDTH-1:0]     rd_val;

  always_comb begin
    slot_sel = addr[REG_ADDR_WIDTH-1:2];
    field    = addr[1:0];
    idx      = slot_sel[IW-1:0];
    in_range = 32'(slot_sel) < QUEUE_DEPTH;
    sel      = slots[idx];
    // armed headers are locked against address/length edits
    locked   = sel.valid &&
               (field == FIELD_START || field == FIELD_NUM);
    req      = wr || rd;
    bad      = (wr && rd) || !in_range ||
               (wr && (field == FIELD_STATUS || locked));
    wr_en    = wr && !bad;
    wr_slot  = idx;
    wr_field = field;
    rd_val   = '0;
    unique case (1'b1)
      field == FIELD_VALIDATE:
        rd_val = DATA_WIDTH'(sel.valid);
      field == FIELD_START:
        rd_val = DATA_WIDTH'(sel.start_addr);
      field == FIELD_NUM:
        rd_val = DATA_WIDTH'(sel.num_words);
      field == FIELD_STATUS:
        rd_val = DATA_WIDTH'({done_cnt, 6'b0,
                              idx == head_idx, sel.valid});
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack       <= 1'b0;
      nack      <= 1'b0;
      read_data <= '0;
    end else begin
      ack       <= req && !bad;
      nack      <= req && bad;
      read_data <= (rd && !bad) ? rd_val : '0;
    end
  end

endmodule

// File: rtl/glb_dma_hdr_queue.sv
// Ring of DMA header slots programmed over PIO, presented head-first.
// Ports: PIO bus, flush, head header out, hdr_done in, head_idx/num_pending out.
module glb_dma_hdr_queue
  import glb_dma_hdr_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH     = 4,
  parameter int ADDR_WIDTH      = 19,
  parameter int NUM_WORDS_WIDTH = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 6,
  localparam int IW = $clog2(QUEUE_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       h2d_pio_dec_write,
  input  logic                       h2d_pio_dec_read,
  input  logic [REG_ADDR_WIDTH-1:0]  h2d_pio_dec_address,
  input  logic [DATA_WIDTH-1:0]      h2d_pio_dec_write_data,
  output logic [DATA_WIDTH-1:0]      d2h_dec_pio_read_data,
  output logic                       d2h_dec_pio_ack,
  output logic                       d2h_dec_pio_nack,
  input  logic                       flush,
  output logic                       hdr_valid,
  output logic [ADDR_WIDTH-1:0]      hdr_start_addr,
  output logic [NUM_WORDS_WIDTH-1:0] hdr_num_words,
  input  logic                       hdr_done,
  output logic [IW-1:0]              head_idx,
  output logic [IW:0]                num_pending
);

  dma_hdr_slot_t         slots [QUEUE_DEPTH];
  dma_hdr_slot_t         head_slot;
  logic [DONE_CNT_W-1:0] done_cnt;
  logic                  wr_en;
  logic [IW-1:0]         wr_slot;
  logic [1:0]            wr_field;
  logic                  done_eff;
  logic [QUEUE_DEPTH-1:0] nxt_valid;
  logic [IW:0]           nxt_pending;

  glb_dma_hdr_pio_dec #(
    .QUEUE_DEPTH    (QUEUE_DEPTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_pio_dec (
    .clk       (clk),
    .reset     (reset),
    .wr        (h2d_pio_dec_write),
    .rd        (h2d_pio_dec_read),
    .addr      (h2d_pio_dec_address),
    .slots     (slots),
    .head_idx  (head_idx),
    .done_cnt  (done_cnt),
    .read_data (d2h_dec_pio_read_data),
    .ack       (d2h_dec_pio_ack),
    .nack      (d2h_dec_pio_nack),
    .wr_en     (wr_en),
    .wr_slot   (wr_slot),
    .wr_field  (wr_field)
  );

  assign head_slot      = slots[head_idx];
  assign hdr_valid      = head_slot.valid;
  assign hdr_start_addr = head_slot.start_addr[ADDR_WIDTH-1:0];
  assign hdr_num_words  = head_slot.num_words[NUM_WORDS_WIDTH-1:0];
  assign done_eff       = hdr_done && head_slot.valid;

  // host validate write is applied after the completion clear,
  // so a same-cycle re-arm of the head slot wins
  always_comb begin
    nxt_valid   = '0;
    nxt_pending = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      nxt_valid[i] = slots[i].valid;
      if (done_eff && IW'(i) == head_idx)
        nxt_valid[i] = 1'b0;
      if (wr_en && wr_field == FIELD_VALIDATE &&
          wr_slot == IW'(i))
        nxt_valid[i] = h2d_pio_dec_write_data[0];
    end
    if (flush)
      nxt_valid = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++)
      nxt_pending = nxt_pending + (IW+1)'(nxt_valid[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++)
        slots[i] <= '0;
      head_idx    <= '0;
      num_pending <= '0;
      done_cnt    <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        slots[i].valid <= nxt_valid[i];
        if (wr_en && wr_slot == IW'(i)) begin
          if (wr_field == FIELD_START)
            slots[i].start_addr <= SLOT_FIELD_W'(
              h2d_pio_dec_write_data[ADDR_WIDTH-1:0]);
          if (wr_field == FIELD_NUM)
            slots[i].num_words <= SLOT_FIELD_W'(
              h2d_pio_dec_write_data[NUM_WORDS_WIDTH-1:0]);
        end
      end
      num_pending <= nxt_pending;
      if (flush)
        head_idx <= '0;
      else if (done_eff)
        head_idx <= head_idx + 1'b1;
      if (done_eff && !flush)
        done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_glb_dma_hdr_queue.sv
// Self-checking bench for glb_dma_hdr_queue (QUEUE_DEPTH=4).
// Vector table for PIO decode plus hand sequences for ring/corner cases.
module tb_glb_dma_hdr_queue;

  logic        clk = 0;
  logic        reset;
  logic        pio_wr, pio_rd;
  logic [5:0]  pio_addr;
  logic [31:0] pio_wdata;
  logic [31:0] pio_rdata;
  logic        pio_ack, pio_nack;
  logic        flush, hdr_done;
  logic        hdr_valid;
  logic [18:0] hdr_start_addr;
  logic [15:0] hdr_num_words;
  logic [1:0]  head_idx;
  logic [2:0]  num_pending;

  int errors = 0;
  int checks = 0;

  glb_dma_hdr_queue dut (
    .clk                    (clk),
    .reset                  (reset),
    .h2d_pio_dec_write      (pio_wr),
    .h2d_pio_dec_read       (pio_rd),
    .h2d_pio_dec_address    (pio_addr),
    .h2d_pio_dec_write_data (pio_wdata),
    .d2h_dec_pio_read_data  (pio_rdata),
    .d2h_dec_pio_ack        (pio_ack),
    .d2h_dec_pio_nack       (pio_nack),
    .flush                  (flush),
    .hdr_valid              (hdr_valid),
    .hdr_start_addr         (hdr_start_addr),
    .hdr_num_words          (hdr_num_words),
    .hdr_done               (hdr_done),
    .head_idx               (head_idx),
    .num_pending            (num_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ack;
    bit          nack;
    logic [31:0] rdata;
    string       nm;
  } exp_t;

  typedef struct {
    bit          w;
    bit          r;
    logic [5:0]  a;
    logic [31:0] d;
    bit          ea;
    bit          en;
    logic [31:0] erd;
    string       nm;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // one PIO cycle, optionally with hdr_done/flush in the same cycle
  task automatic pio(input bit w, input bit r, input logic [5:0] a,
                     input logic [31:0] d, input bit dn, input bit fl,
                     input bit ea, input bit en,
                     input logic [31:0] erd, input string nm);
    exp_t e;
    @(negedge clk);
    pio_wr = w; pio_rd = r; pio_addr = a; pio_wdata = d;
    hdr_done = dn; flush = fl;
    if (w || r) begin
      e.ack = ea; e.nack = en; e.rdata = erd; e.nm = nm;
      sb.push_back(e);
    end
    @(negedge clk);
    pio_wr = 0; pio_rd = 0; hdr_done = 0; flush = 0;
    if (w || r) begin
      if (!(pio_ack || pio_nack)) begin
        checks++; errors++;
        $display("FAIL %s: no ack/nack response", nm);
        void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        chk({e.nm, ".ack"}, 32'(pio_ack), 32'(e.ack));
        chk({e.nm, ".nack"}, 32'(pio_nack), 32'(e.nack));
        chk({e.nm, ".rdata"}, pio_rdata, e.rdata);
      end
    end
  endtask

  task automatic wr_ok(input logic [5:0] a, input logic [31:0] d);
    pio(1, 0, a, d, 0, 0, 1, 0, 0, "wr");
  endtask

  task automatic done_pulse();
    pio(0, 0, 0, 0, 1, 0, 0, 0, 0, "done");
  endtask

  initial begin
    reset = 1; pio_wr = 0; pio_rd = 0; pio_addr = 0; pio_wdata = 0;
    flush = 0; hdr_done = 0;
    #12;
    chk("rst.hdr_valid", 32'(hdr_valid), 0);
    chk("rst.head_idx", 32'(head_idx), 0);
    chk("rst.num_pending", 32'(num_pending), 0);
    chk("rst.ack", 32'(pio_ack), 0);
    chk("rst.rdata", pio_rdata, 0);
    @(negedge clk);
    reset = 0;

    tbl[0]  = '{0,1,6'd3, 0,      1,0,32'h0002,"st0_head"};
    tbl[1]  = '{1,0,6'd1, 'h100,  1,0,0,       "wr_start0"};
    tbl[2]  = '{1,0,6'd2, 64,     1,0,0,       "wr_num0"};
    tbl[3]  = '{1,0,6'd0, 1,      1,0,0,       "arm0"};
    tbl[4]  = '{0,1,6'd1, 0,      1,0,32'h100, "rd_start0"};
    tbl[5]  = '{1,0,6'd1, 'h200,  0,1,0,       "wr_locked"};
    tbl[6]  = '{0,1,6'd1, 0,      1,0,32'h100, "rd_unchanged"};
    tbl[7]  = '{1,0,6'd17,5,      0,1,0,       "wr_slot4"};
    tbl[8]  = '{1,1,6'd5, 5,      0,1,0,       "rd_and_wr"};
    tbl[9]  = '{1,0,6'd7, 5,      0,1,0,       "wr_status"};
    tbl[10] = '{0,1,6'd3, 0,      1,0,32'h0003,"st0_armed"};
    tbl[11] = '{0,1,6'd0, 0,      1,0,32'h1,   "rd_valid0"};
    tbl[12] = '{0,1,6'd21,0,      0,1,0,       "rd_slot5"};
    for (int i = 0; i < 13; i++)
      pio(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, 0, 0,
          tbl[i].ea, tbl[i].en, tbl[i].erd, tbl[i].nm);
    chk("h0.valid", 32'(hdr_valid), 1);
    chk("h0.start", 32'(hdr_start_addr), 'h100);
    chk("h0.num", 32'(hdr_num_words), 64);
    chk("h0.pending", 32'(num_pending), 1);

    // fill the ring and drain it
    for (int i = 1; i < 4; i++) begin
      wr_ok(6'(4*i+1), 32'(256*(i+1)));
      wr_ok(6'(4*i+2), 32'(64+i));
      wr_ok(6'(4*i), 1);
    end
    chk("ring.pending4", 32'(num_pending), 4);
    for (int i = 0; i < 4; i++) begin
      done_pulse();
      chk($sformatf("ring.head%0d", i), 32'(head_idx), (i+1)%4);
    end
    chk("ring.valid", 32'(hdr_valid), 0);
    chk("ring.pending0", 32'(num_pending), 0);
    done_pulse();
    chk("idle_done.head", 32'(head_idx), 0);
    pio(0,1,6'd3,0,0,0,1,0,32'h0402,"ring.cnt4");

    // completion and re-arm of head slot 2 in one cycle
    wr_ok(6'd0, 1); wr_ok(6'd4, 1); wr_ok(6'd8, 1);
    done_pulse(); done_pulse();
    chk("sim.head2", 32'(head_idx), 2);
    pio(1,0,6'd8,1,1,0,1,0,0,"sim.rearm");
    chk("sim.head3", 32'(head_idx), 3);
    chk("sim.pending", 32'(num_pending), 1);
    pio(0,1,6'd11,0,0,0,1,0,32'h0701,"sim.st2");

    // flush overrides hdr_done, PIO read still acked
    wr_ok(6'd12, 1); wr_ok(6'd0, 1);
    chk("fl.pending3", 32'(num_pending), 3);
    chk("fl.hstart", 32'(hdr_start_addr), 'h400);
    pio(0,1,6'd3,0,1,1,1,0,32'h0701,"fl.rd");
    chk("fl.head", 32'(head_idx), 0);
    chk("fl.pending0", 32'(num_pending), 0);
    chk("fl.valid", 32'(hdr_valid), 0);
    chk("fl.start_kept", 32'(hdr_start_addr), 'h100);
    chk("fl.num_kept", 32'(hdr_num_words), 64);
    pio(0,1,6'd3,0,0,0,1,0,32'h0702,"fl.cnt_kept");

    // disarm head in the completion cycle counts once
    wr_ok(6'd0, 1);
    pio(1,0,6'd0,0,1,0,1,0,0,"dis.wr");
    chk("dis.head", 32'(head_idx), 1);
    chk("dis.pending", 32'(num_pending), 0);
    pio(0,1,6'd3,0,0,0,1,0,32'h0800,"dis.cnt");

    // reset while an ack is in flight
    wr_ok(6'd0, 1);
    @(negedge clk);
    pio_rd = 1; pio_addr = 6'd3;
    @(posedge clk);
    #1 reset = 1;
    #1;
    pio_rd = 0;
    chk("mid_rst.ack", 32'(pio_ack), 0);
    chk("mid_rst.valid", 32'(hdr_valid), 0);
    chk("mid_rst.pending", 32'(num_pending), 0);
    chk("mid_rst.head", 32'(head_idx), 0);
    @(negedge clk);
    reset = 0;
    pio(0,1,6'd3,0,0,0,1,0,32'h0002,"mid_rst.st0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
